// File: rtl/in_mem_ctrl.sv
// rtl/in_mem_ctrl.sv - sample-memory write/tap-read sequencer with zero-run sleep
module in_mem_ctrl #(
   parameter int TAPS     = 256,
   parameter int ZERO_RUN = 800
) (
   input  logic        Sclk,
   input  logic        Reset_n,
   input  logic        sample_valid,
   input  logic [15:0] sample_L,
   input  logic [15:0] sample_R,
   output logic        wr_en,
   output logic [9:0]  wr_row,
   output logic [15:0] wr_data_L,
   output logic [15:0] wr_data_R,
   output logic        clear,
   output logic [8:0]  rd_index,
   output logic        rd_valid,
   output logic        rd_last,
   output logic        frame_done,
   output logic        sleep,
   output logic        overrun
);

   localparam int ZW = $clog2(ZERO_RUN + 1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DONE, S_CLEAR, S_SLEEP} state_t;

   state_t         state_q;
   logic [8:0]     wr_ptr_q, base_q, rd_index_q;
   logic [9:0]     k_q, wr_row_q;
   logic [ZW-1:0]  zcnt_q, zcnt_d;
   logic [15:0]    data_l_q, data_r_q;
   logic           wr_en_q, clear_q, rd_valid_q, rd_last_q, frame_done_q, sleep_q, overrun_q;

   logic           is_zero, accept, busy, k_last;
   logic [9:0]     k_nxt;

   assign is_zero = (sample_L == 16'd0) && (sample_R == 16'd0);
   // A sleeping controller only wakes on a nonzero pair; zero pairs are silently ignored.
   assign accept  = sample_valid && ((state_q == S_IDLE) || ((state_q == S_SLEEP) && !is_zero));
   assign busy    = (state_q == S_WRITE) || (state_q == S_READ) ||
                    (state_q == S_DONE)  || (state_q == S_CLEAR);
   assign k_nxt   = k_q + 10'd1;
   assign k_last  = (k_q == 10'(TAPS - 1));

   always_comb begin
      zcnt_d = '0;
      if (is_zero)
         zcnt_d = (zcnt_q == ZW'(ZERO_RUN)) ? zcnt_q : zcnt_q + 1'b1;
   end

   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         base_q       <= '0;
         k_q          <= '0;
         zcnt_q       <= '0;
         wr_row_q     <= '0;
         data_l_q     <= '0;
         data_r_q     <= '0;
         rd_index_q   <= '0;
         wr_en_q      <= 1'b0;
         clear_q      <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         frame_done_q <= 1'b0;
         sleep_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         wr_en_q      <= 1'b0;
         clear_q      <= 1'b0;
         frame_done_q <= 1'b0;
         if (sample_valid && busy)
            overrun_q <= 1'b1;
         case (state_q)
            S_IDLE, S_SLEEP: begin
               if (accept) begin
                  data_l_q <= sample_L;
                  data_r_q <= sample_R;
                  zcnt_q   <= zcnt_d;
                  wr_en_q  <= 1'b1;
                  wr_row_q <= {1'b0, wr_ptr_q};
                  base_q   <= wr_ptr_q;
                  wr_ptr_q <= wr_ptr_q + 9'd1;
                  sleep_q  <= 1'b0;
                  state_q  <= S_WRITE;
               end
            end
            S_WRITE: begin
               k_q        <= '0;
               rd_valid_q <= 1'b1;
               rd_index_q <= base_q;
               rd_last_q  <= (TAPS == 1);
               state_q    <= S_READ;
            end
            S_READ: begin
               if (k_last) begin
                  rd_valid_q   <= 1'b0;
                  rd_last_q    <= 1'b0;
                  frame_done_q <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  k_q        <= k_nxt;
                  rd_index_q <= base_q - k_nxt[8:0];
                  rd_last_q  <= (k_nxt == 10'(TAPS - 1));
               end
            end
            S_DONE: begin
               // The count only reaches ZERO_RUN on the frame of the triggering zero pair.
               if (zcnt_q == ZW'(ZERO_RUN)) begin
                  clear_q  <= 1'b1;
                  wr_ptr_q <= '0;
                  state_q  <= S_CLEAR;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CLEAR: begin
               sleep_q <= 1'b1;
               state_q <= S_SLEEP;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_row     = wr_row_q;
   assign wr_data_L  = data_l_q;
   assign wr_data_R  = data_r_q;
   assign clear      = clear_q;
   assign rd_index   = rd_index_q;
   assign rd_valid   = rd_valid_q;
   assign rd_last    = rd_last_q;
   assign frame_done = frame_done_q;
   assign sleep      = sleep_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_in_mem_ctrl.sv
// tb/tb_in_mem_ctrl.sv - randomized bench for in_mem_ctrl against a schedule-based model
module tb_in_mem_ctrl;

   localparam int TAPS = 4;
   localparam int ZR   = 3;
   localparam int NC   = 16384;

   logic        Sclk = 1'b0;
   logic        Reset_n;
   logic        sample_valid;
   logic [15:0] sample_L, sample_R;
   logic        wr_en, clear, rd_valid, rd_last, frame_done, sleep, overrun;
   logic [9:0]  wr_row;
   logic [15:0] wr_data_L, wr_data_R;
   logic [8:0]  rd_index;

   in_mem_ctrl #(.TAPS(TAPS), .ZERO_RUN(ZR)) dut (
      .Sclk(Sclk), .Reset_n(Reset_n), .sample_valid(sample_valid),
      .sample_L(sample_L), .sample_R(sample_R), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data_L(wr_data_L), .wr_data_R(wr_data_R), .clear(clear), .rd_index(rd_index),
      .rd_valid(rd_valid), .rd_last(rd_last), .frame_done(frame_done), .sleep(sleep),
      .overrun(overrun)
   );

   always #5 Sclk = ~Sclk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Expected per-cycle outputs, filled in ahead of time when a sample is accepted.
   bit          exp_wr[NC], exp_clr[NC], exp_rv[NC], exp_rl[NC], exp_fd[NC];
   logic [9:0]  exp_row[NC];
   logic [8:0]  exp_ri[NC];
   logic [15:0] exp_dl[NC], exp_dr[NC];

   int busy_end, sleep_start, sleep_end, ptr, zcnt, ovr_from;
   bit ovr_set;
   logic [9:0] h_row;
   logic [8:0] h_ri;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = cyc + 1; i < NC; i++) begin
         exp_wr[i] = 0; exp_clr[i] = 0; exp_rv[i] = 0; exp_rl[i] = 0; exp_fd[i] = 0;
      end
      busy_end = -10; sleep_start = -1; sleep_end = -1;
      ptr = 0; zcnt = 0; ovr_set = 0; ovr_from = 0;
      h_row = '0; h_ri = '0;
   endtask

   task automatic model_edge(input int m, input bit v, input logic [15:0] l, input logic [15:0] r);
      bit zero;
      if (!v || m + TAPS + 4 >= NC) return;
      zero = (l == 0) && (r == 0);
      if (sleep_start >= 0 && sleep_end < 0 && m - 1 >= sleep_start) begin
         if (zero) return;
         sleep_end = m;
      end else if (m - 1 <= busy_end) begin
         if (!ovr_set) begin ovr_set = 1; ovr_from = m; end
         return;
      end
      zcnt = zero ? ((zcnt + 1 > ZR) ? ZR : zcnt + 1) : 0;
      exp_wr[m] = 1; exp_row[m] = 10'(ptr); exp_dl[m] = l; exp_dr[m] = r;
      for (int k = 0; k < TAPS; k++) begin
         exp_rv[m + 1 + k] = 1;
         exp_ri[m + 1 + k] = 9'((ptr - k + 512) % 512);
         exp_rl[m + 1 + k] = (k == TAPS - 1);
      end
      exp_fd[m + TAPS + 1] = 1;
      busy_end = m + TAPS + 1;
      ptr = (ptr + 1) % 512;
      if (zero && zcnt == ZR) begin
         exp_clr[m + TAPS + 2] = 1;
         busy_end = m + TAPS + 2;
         sleep_start = m + TAPS + 3;
         sleep_end = -1;
         ptr = 0;
      end
   endtask

   task automatic check_cycle(input int c);
      bit slp, ovr;
      if (exp_wr[c]) h_row = exp_row[c];
      if (exp_rv[c]) h_ri = exp_ri[c];
      slp = (sleep_start >= 0) && (c >= sleep_start) && (sleep_end < 0 || c < sleep_end);
      ovr = ovr_set && (c >= ovr_from);
      chk("strobes", {25'd0, wr_en, clear, rd_valid, rd_last, frame_done, sleep, overrun},
          {25'd0, exp_wr[c], exp_clr[c], exp_rv[c], exp_rl[c], exp_fd[c], slp, ovr});
      chk("rd_index", 32'(rd_index), 32'(h_ri));
      chk("wr_row", 32'(wr_row), 32'(h_row));
      if (exp_wr[c]) chk("wr_data", {wr_data_L, wr_data_R}, {exp_dl[c], exp_dr[c]});
   endtask

   task automatic tick(input bit v, input logic [15:0] l, input logic [15:0] r);
      sample_valid = v; sample_L = l; sample_R = r;
      if (Reset_n) model_edge(cyc + 1, v, l, r);
      @(posedge Sclk);
      cyc++;
      @(negedge Sclk);
      check_cycle(cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 16'h0, 16'h0);
   endtask

   initial begin
      logic [15:0] l, r;
      Reset_n = 1'b0; sample_valid = 1'b0; sample_L = '0; sample_R = '0;
      model_reset();
      @(negedge Sclk);
      idle(2);
      Reset_n = 1'b1;
      idle(2);

      tick(1, 16'h1234, 16'hABCD);
      idle(TAPS + 4);

      tick(1, 16'h0042, 16'h0007);
      idle(2);
      tick(1, 16'h0BAD, 16'h0BAD);
      idle(TAPS + 4);

      for (int i = 0; i < 513; i++) begin
         l = 16'($urandom_range(1, 65535));
         r = 16'($urandom);
         tick(1, l, r);
         idle(TAPS + 3 + $urandom_range(0, 2));
      end

      for (int i = 0; i < ZR; i++) begin
         tick(1, 16'h0, 16'h0);
         idle(TAPS + 4);
      end
      for (int i = 0; i < 5; i++) begin
         tick(1, 16'h0, 16'h0);
         idle(1);
      end
      tick(1, 16'h0001, 16'h0000);
      idle(TAPS + 4);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 2) == 0) begin l = '0; r = '0; end
            else begin l = 16'($urandom); r = 16'($urandom); end
            tick(1, l, r);
         end else begin
            tick(0, 16'h0, 16'h0);
         end
      end
      idle(TAPS + 4);
      tick(1, 16'h7777, 16'h0);
      idle(TAPS + 4);

      tick(1, 16'h5A5A, 16'hA5A5);
      idle(3);
      Reset_n = 1'b0;
      #1;
      chk("rst_async_strobes", {25'd0, wr_en, clear, rd_valid, rd_last, frame_done, sleep, overrun}, 32'd0);
      chk("rst_async_rd_index", 32'(rd_index), 32'd0);
      chk("rst_async_wr_data", {wr_data_L, wr_data_R}, 32'd0);
      model_reset();
      idle(2);
      Reset_n = 1'b1;
      tick(1, 16'h5555, 16'h6666);
      idle(TAPS + 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
